// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU for the RV32 execute stage.
// Single-cycle integer/bit-count ops finish one cycle after accept; M-extension
// ops iterate one radix-2 step per cycle for a fixed XLEN+1 cycle latency.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an op, in_ready=1
// CALC  | M op iterating (shift-add multiply or restoring divide)
// DONE  | result registered, out_valid=1 until out_ready
module alu_seq #(
  parameter int  XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = SHW + 1;

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SUB    = 5'h01;
  localparam logic [4:0] OP_AND    = 5'h02;
  localparam logic [4:0] OP_OR     = 5'h03;
  localparam logic [4:0] OP_XOR    = 5'h04;
  localparam logic [4:0] OP_SLL    = 5'h05;
  localparam logic [4:0] OP_SRL    = 5'h06;
  localparam logic [4:0] OP_SRA    = 5'h07;
  localparam logic [4:0] OP_SLT    = 5'h08;
  localparam logic [4:0] OP_SLTU   = 5'h09;
  localparam logic [4:0] OP_EQ     = 5'h0A;
  localparam logic [4:0] OP_NE     = 5'h0B;
  localparam logic [4:0] OP_GE     = 5'h0C;
  localparam logic [4:0] OP_GEU    = 5'h0D;
  localparam logic [4:0] OP_ADD4   = 5'h0E;
  localparam logic [4:0] OP_PASSB  = 5'h0F;
  localparam logic [4:0] OP_CPOP   = 5'h10;
  localparam logic [4:0] OP_CLZ    = 5'h11;
  localparam logic [4:0] OP_CTZ    = 5'h12;
  localparam logic [4:0] OP_MUL    = 5'h13;
  localparam logic [4:0] OP_MULH   = 5'h14;
  localparam logic [4:0] OP_MULHSU = 5'h15;
  localparam logic [4:0] OP_MULHU  = 5'h16;
  localparam logic [4:0] OP_DIV    = 5'h17;
  localparam logic [4:0] OP_DIVU   = 5'h18;
  localparam logic [4:0] OP_REM    = 5'h19;
  localparam logic [4:0] OP_REMU   = 5'h1A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4:0]          op_q, op_d;
  logic                neg_a_q, neg_a_d;
  logic                neg_b_q, neg_b_d;

  logic                accept;
  logic                is_mop;
  logic                is_div_in;
  logic                is_div_q;
  logic                sign_a, sign_b;
  logic                neg_a_in, neg_b_in;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic [SHW-1:0]      shamt;
  logic [CW-1:0]       cpop_v, clz_v, ctz_v;
  logic [XLEN-1:0]     single_res;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_hi;
  logic [XLEN:0]       div_trial;
  logic [2*XLEN-1:0]   acc_step;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo, rem;
  logic                div_zero;
  logic [XLEN-1:0]     m_res;

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC);
  assign result    = result_q;

  assign accept    = in_valid & in_ready;
  assign is_mop    = (op >= OP_MUL) && (op <= OP_REMU);
  assign is_div_in = is_mop && (op >= OP_DIV);
  assign is_div_q  = (op_q >= OP_DIV);
  assign shamt     = b[SHW-1:0];

  // Population count and leading/trailing zero counts of operand a
  always_comb begin
    cpop_v = '0;
    clz_v  = CW'(XLEN);
    ctz_v  = CW'(XLEN);
    for (int i = 0; i < XLEN; i++) begin
      cpop_v = cpop_v + CW'(a[i]);
      if (a[i]) clz_v = CW'(XLEN - 1 - i);
    end
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (a[i]) ctz_v = CW'(i);
    end
  end

  // Single-cycle result; unused and M op codes evaluate to zero here
  always_comb begin
    single_res = '0;
    case (op)
      OP_ADD:   single_res = a + b;
      OP_SUB:   single_res = a - b;
      OP_AND:   single_res = a & b;
      OP_OR:    single_res = a | b;
      OP_XOR:   single_res = a ^ b;
      OP_SLL:   single_res = a << shamt;
      OP_SRL:   single_res = a >> shamt;
      OP_SRA:   single_res = $unsigned($signed(a) >>> shamt);
      OP_SLT:   single_res[0] = ($signed(a) < $signed(b));
      OP_SLTU:  single_res[0] = (a < b);
      OP_EQ:    single_res[0] = (a == b);
      OP_NE:    single_res[0] = (a != b);
      OP_GE:    single_res[0] = ($signed(a) >= $signed(b));
      OP_GEU:   single_res[0] = (a >= b);
      OP_ADD4:  single_res = a + XLEN'(4);
      OP_PASSB: single_res = b;
      OP_CPOP:  single_res = XLEN'(cpop_v);
      OP_CLZ:   single_res = XLEN'(clz_v);
      OP_CTZ:   single_res = XLEN'(ctz_v);
      default:  single_res = '0;
    endcase
  end

  // Operand signedness for M ops; iteration always runs on magnitudes
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        sign_a = 1'b1;
        sign_b = 1'b1;
      end
      OP_MULHSU: sign_a = 1'b1;
      default: ;
    endcase
    neg_a_in = sign_a & a[XLEN-1];
    neg_b_in = sign_b & b[XLEN-1];
    abs_a    = neg_a_in ? (~a + XLEN'(1)) : a;
    abs_b    = neg_b_in ? (~b + XLEN'(1)) : b;
  end

  // One radix-2 step: multiply keeps {partial, multiplier}, divide keeps {remainder, quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    div_hi    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_trial = div_hi - {1'b0, opnd_q};
    if (is_div_q) begin
      if (div_trial[XLEN]) acc_step = {div_hi[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else                 acc_step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else if (acc_q[0]) begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end else begin
      acc_step = {1'b0, acc_q[2*XLEN-1:1]};
    end
  end

  // Sign fix and special cases applied to the final iteration's output.
  // Divide-by-zero leaves the full dividend magnitude in the remainder, so after
  // the dividend-sign fix REM/REMU return a; signed overflow also falls out
  // naturally (quotient magnitude 2^(XLEN-1), remainder 0).
  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_step + (2*XLEN)'(1)) : acc_step;
    quo      = acc_step[XLEN-1:0];
    rem      = acc_step[2*XLEN-1:XLEN];
    div_zero = (opnd_q == '0);
    case (op_q)
      OP_MUL:                       m_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: m_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (div_zero)                m_res = '1;
        else if (neg_a_q ^ neg_b_q)  m_res = ~quo + XLEN'(1);
        else                         m_res = quo;
      end
      default:                      m_res = neg_a_q ? (~rem + XLEN'(1)) : rem;
    endcase
  end

  // Next-state logic: accept from IDLE or from DONE while the result is taken
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (is_mop) begin
            op_d    = op;
            neg_a_d = neg_a_in;
            neg_b_d = neg_b_in;
            cnt_d   = CW'(XLEN);
            if (is_div_in) begin
              acc_d  = {{XLEN{1'b0}}, abs_a};
              opnd_d = abs_b;
            end else begin
              acc_d  = {{XLEN{1'b0}}, abs_b};
              opnd_d = abs_a;
            end
            state_d = S_CALC;
          end else begin
            result_d = single_res;
            state_d  = S_DONE;
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = m_res;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a behavioural model.
module tb_alu_seq;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_m(input logic [4:0] o);
    return (o >= 5'h13) && (o <= 5'h1A);
  endfunction

  // Reference: plain 64-bit arithmetic straight from the op definitions
  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q;
    logic [63:0] p;
    int          n;
    logic [31:0] r;
    bit          ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    r   = '0;
    case (o)
      5'h00: r = x + y;
      5'h01: r = x - y;
      5'h02: r = x & y;
      5'h03: r = x | y;
      5'h04: r = x ^ y;
      5'h05: r = x << y[4:0];
      5'h06: r = x >> y[4:0];
      5'h07: r = $unsigned($signed(x) >>> y[4:0]);
      5'h08: r = {31'b0, sx < sy};
      5'h09: r = {31'b0, x < y};
      5'h0A: r = {31'b0, x == y};
      5'h0B: r = {31'b0, x != y};
      5'h0C: r = {31'b0, sx >= sy};
      5'h0D: r = {31'b0, x >= y};
      5'h0E: r = x + 32'd4;
      5'h0F: r = y;
      5'h10: r = 32'($countones(x));
      5'h11: begin n = 0; while (n < 32 && !x[31-n]) n++; r = 32'(n); end
      5'h12: begin n = 0; while (n < 32 && !x[n]) n++; r = 32'(n); end
      5'h13: begin p = 64'(sx * sy); r = p[31:0]; end
      5'h14: begin p = 64'(sx * sy); r = p[63:32]; end
      5'h15: begin p = 64'(sx * longint'({32'b0, y})); r = p[63:32]; end
      5'h16: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
      5'h17: begin
        if (y == 0) r = '1;
        else if (ovf) r = x;
        else begin q = sx / sy; r = q[31:0]; end
      end
      5'h18: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'h19: begin
        if (y == 0) r = x;
        else if (ovf) r = '0;
        else begin q = sx % sy; r = q[31:0]; end
      end
      5'h1A: r = (y == 0) ? x : x % y;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 16));
      5:       return ~32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op with out_ready=1 from a point #1 after a clock edge; check latency and result
  task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input string tag);
    int lat;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op       = 5'($urandom);
    a        = $urandom;
    b        = $urandom;
    lat      = 1;
    if (is_m(o)) chk({tag, " busy"}, 32'(busy), 32'd1);
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), is_m(o) ? 32'(XLEN + 1) : 32'd1);
    chk({tag, " result"}, result, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ro;
    logic [31:0] rx, ry;
    logic [31:0] sa [4];
    logic [31:0] sb [4];
    int          n;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset result", result, 32'd0);

    // ADD with the result held under back-pressure
    @(posedge clk); #1;
    in_valid = 1'b1; op = 5'h00; a = 32'd5; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    chk("hold out_valid", 32'(out_valid), 32'd1);
    chk("hold result", result, 32'd12);
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold result stable", result, 32'd12);
      chk("hold out_valid stable", 32'(out_valid), 32'd1);
      chk("hold in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release out_valid", 32'(out_valid), 32'd0);

    // Directed values with hand-derived expectations
    run_op(5'h16, 32'hFFFF_FFFF, 32'h3,         32'h0000_0002, "MULHU");
    run_op(5'h13, 32'hFFFF_FFFF, 32'h3,         32'hFFFF_FFFD, "MUL");
    run_op(5'h14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "MULH");
    run_op(5'h15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU");
    run_op(5'h17, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf");
    run_op(5'h19, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "REM ovf");
    run_op(5'h18, 32'h7,         32'h0,         32'hFFFF_FFFF, "DIVU by0");
    run_op(5'h1A, 32'h7,         32'h0,         32'h0000_0007, "REMU by0");
    run_op(5'h17, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFFF, "DIV neg by0");
    run_op(5'h19, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, "REM neg by0");
    run_op(5'h17, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, "DIV -7/2");
    run_op(5'h19, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, "REM -7/2");
    run_op(5'h11, 32'h0001_0000, 32'h0,         32'd15,        "CLZ");
    run_op(5'h11, 32'h0000_0000, 32'h0,         32'd32,        "CLZ zero");
    run_op(5'h12, 32'h0000_0000, 32'h0,         32'd32,        "CTZ zero");
    run_op(5'h10, 32'hF0F0_F0F0, 32'h0,         32'd16,        "CPOP");
    run_op(5'h1F, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0,         "op1F");
    run_op(5'h07, 32'h8000_0000, 32'h24,        32'hF800_0000, "SRA mask");

    // Reset in the middle of a DIV discards it
    in_valid = 1'b1; op = 5'h17; a = $urandom; b = $urandom | 32'h1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid-DIV busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort result", result, 32'd0);
    run_op(5'h00, 32'd1, 32'd1, 32'd2, "ADD after reset");

    // Stream four ADDs, then a MUL stalls the next op
    for (int i = 0; i < 4; i++) begin
      sa[i] = $urandom;
      sb[i] = $urandom;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; op = 5'h00; a = sa[i]; b = sb[i];
      @(posedge clk); #1;
      chk("stream out_valid", 32'(out_valid), 32'd1);
      chk("stream result", result, sa[i] + sb[i]);
    end
    rx = $urandom; ry = $urandom;
    op = 5'h13; a = rx; b = ry;
    @(posedge clk); #1;
    op = 5'h01; a = 32'd100; b = 32'd58;
    n = 1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("MUL stall cycles", 32'(n), 32'd33);
    chk("MUL stream result", result, model(5'h13, rx, ry));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("after-stall SUB", result, 32'd42);
    chk("after-stall out_valid", 32'(out_valid), 32'd1);

    // Randomized ops against the reference model
    for (int i = 0; i < 300; i++) begin
      ro = 5'($urandom_range(0, 31));
      rx = rnd_val();
      ry = rnd_val();
      run_op(ro, rx, ry, model(ro, rx, ry), $sformatf("rand op%02h a=%h b=%h", ro, rx, ry));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
